// File: rtl/native2axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : native2axis_pkg
// Brief    : Shared types and helpers for the native-to-AXIS video converter.
// Revision : 1.0 - initial release
// ============================================================================
package native2axis_pkg;

    localparam int c_DEF_DATA_WID = 24;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        DROP     = 2'd2
    } state_t;

    // FIFO word layout, MSB first: tuser, tlast, pixel data.
    typedef struct packed {
        logic                      tuser;
        logic                      tlast;
        logic [c_DEF_DATA_WID-1:0] data;
    } fifo_word_t;

    function automatic int fifo_width(input int data_wid);
        return data_wid + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qwi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qwi_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with registered output.
// Revision : 1.0 - initial release
// ============================================================================
module qwi_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_mem_cnt;
    logic [c_AW:0]    w_total;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             w_pop;
    logic             w_push;
    logic             w_load;

    // Capacity counts the output register, so DEPTH is the true entry count.
    assign w_pop   = rd_en & r_out_valid;
    assign w_total = r_mem_cnt + {{c_AW{1'b0}}, r_out_valid};
    assign full    = (w_total == c_FULL);
    assign w_push  = wr_en & (~full | w_pop);
    assign w_load  = (r_mem_cnt != '0) & (~r_out_valid | w_pop);

    assign rd_data = r_out_data;
    assign empty   = ~r_out_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_load) begin
                r_out_data  <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + c_AW'(1);
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            case ({w_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + (c_AW+1)'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - (c_AW+1)'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/native2axis.sv
`default_nettype none
// ============================================================================
// Module   : native2axis
// Brief    : Native video stream to AXI4-Stream video with elastic FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module native2axis
    import native2axis_pkg::*;
#(
    parameter int DATA_WID   = c_DEF_DATA_WID,
    parameter int FIFO_DEPTH = 2048,
    parameter int CNT_WID    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  natv_active,
    input  logic [DATA_WID-1:0]   natv_data,
    input  logic                  natv_hsync,
    input  logic                  natv_vsync,
    input  logic                  natv_hblank,
    input  logic                  natv_vblank,
    output logic [DATA_WID-1:0]   m_axis_tdata,
    output logic [DATA_WID/8-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  ovf_clr,
    output logic                  ovf_sticky,
    output logic [CNT_WID-1:0]    ppl_meas,
    output logic [CNT_WID-1:0]    lpf_meas
);

    localparam int c_FIFO_WID = fifo_width(DATA_WID);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_vblank_d;
    logic                  r_active_d;
    logic                  r_sof_pending;
    logic                  r_ovf_sticky;
    logic                  r_stg_valid;
    logic                  r_stg_tuser;
    logic [DATA_WID-1:0]   r_stg_data;
    logic [CNT_WID-1:0]    r_pix_cnt;
    logic [CNT_WID-1:0]    r_line_cnt;
    logic [CNT_WID-1:0]    r_ppl_meas;
    logic [CNT_WID-1:0]    r_lpf_meas;
    logic                  w_vblank_rise;
    logic                  w_accept;
    logic                  w_counting;
    logic                  w_line_end;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_ovf;
    logic [c_FIFO_WID-1:0] w_wr_word;
    logic [c_FIFO_WID-1:0] w_rd_word;
    logic                  w_unused;

    assign w_unused      = natv_hsync ^ natv_vsync ^ natv_hblank;
    assign w_vblank_rise = natv_vblank & ~r_vblank_d;
    assign w_line_end    = r_active_d & ~natv_active & w_counting;

    // A staged pixel may enter a full FIFO only if a beat leaves in the same cycle.
    assign w_rd  = m_axis_tready & ~w_fifo_empty;
    assign w_wr  = r_stg_valid & (~w_fifo_full | w_rd);
    assign w_ovf = r_stg_valid & ~w_wr;

    // The staged pixel's tlast is decided by whether the line continues now.
    assign w_wr_word = {r_stg_tuser, ~natv_active, r_stg_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_counting  = 1'b1;
        case (r_state)
            WAIT_SOF: begin
                w_counting = 1'b0;
                if (w_vblank_rise) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_accept = natv_active & ~w_ovf;
                if (w_vblank_rise) begin
                    w_state_nxt = RUN;
                end else if (w_ovf) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (w_vblank_rise) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_counting  = 1'b0;
                w_state_nxt = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblank_d    <= 1'b0;
            r_active_d    <= 1'b0;
            r_sof_pending <= 1'b0;
            r_ovf_sticky  <= 1'b0;
            r_stg_valid   <= 1'b0;
            r_stg_tuser   <= 1'b0;
            r_stg_data    <= '0;
        end else begin
            r_vblank_d  <= natv_vblank;
            r_active_d  <= natv_active;
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_data  <= natv_data;
                r_stg_tuser <= r_sof_pending;
            end
            if (w_vblank_rise) begin
                r_sof_pending <= 1'b1;
            end else if (w_accept) begin
                r_sof_pending <= 1'b0;
            end
            if (w_ovf) begin
                r_ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_ppl_meas <= '0;
            r_lpf_meas <= '0;
        end else begin
            if (w_line_end) begin
                r_ppl_meas <= r_pix_cnt;
                r_pix_cnt  <= '0;
            end else if (w_counting && natv_active && (r_pix_cnt != '1)) begin
                r_pix_cnt <= r_pix_cnt + CNT_WID'(1);
            end
            if (w_vblank_rise) begin
                r_lpf_meas <= r_line_cnt;
                r_line_cnt <= '0;
            end else if (w_line_end && (r_line_cnt != '1)) begin
                r_line_cnt <= r_line_cnt + CNT_WID'(1);
            end
        end
    end

    qwi_sync_fifo #(
        .WIDTH (c_FIFO_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data (w_wr_word),
        .full    (w_fifo_full),
        .rd_en   (m_axis_tready),
        .rd_data (w_rd_word),
        .empty   (w_fifo_empty)
    );

    assign m_axis_tvalid = ~w_fifo_empty;
    assign m_axis_tuser  = w_rd_word[c_FIFO_WID-1];
    assign m_axis_tlast  = w_rd_word[c_FIFO_WID-2];
    assign m_axis_tdata  = w_rd_word[DATA_WID-1:0];
    assign m_axis_tkeep  = '1;
    assign ovf_sticky    = r_ovf_sticky;
    assign ppl_meas      = r_ppl_meas;
    assign lpf_meas      = r_lpf_meas;

endmodule
`default_nettype wire

// File: tb/tb_native2axis.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_native2axis
// Brief    : Directed self-checking bench for native2axis (two FIFO depths).
// Revision : 1.0 - initial release
// ============================================================================
module tb_native2axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        natv_active = 1'b0;
    logic [23:0] natv_data = '0;
    logic        natv_hsync = 1'b0;
    logic        natv_vsync = 1'b0;
    logic        natv_hblank = 1'b1;
    logic        natv_vblank = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        tready_a = 1'b1;
    logic        tready_b = 1'b1;

    logic [23:0] tdata_a, tdata_b;
    logic [2:0]  tkeep_a, tkeep_b;
    logic        tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b;
    logic        ovf_a, ovf_b;
    logic [11:0] ppl_a, ppl_b, lpf_a, lpf_b;

    int          n_vec = 0;
    int          n_err = 0;
    logic [25:0] q_a[$];
    logic [25:0] q_b[$];
    logic        stall_a = 1'b0;
    logic [25:0] held_a = '0;
    int          stall_err = 0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    native2axis #(.DATA_WID(24), .FIFO_DEPTH(2048), .CNT_WID(12)) dut_a (
        .clk(clk), .rst(rst), .natv_active(natv_active), .natv_data(natv_data),
        .natv_hsync(natv_hsync), .natv_vsync(natv_vsync), .natv_hblank(natv_hblank),
        .natv_vblank(natv_vblank), .m_axis_tdata(tdata_a), .m_axis_tkeep(tkeep_a),
        .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a), .m_axis_tuser(tuser_a),
        .m_axis_tlast(tlast_a), .ovf_clr(ovf_clr), .ovf_sticky(ovf_a),
        .ppl_meas(ppl_a), .lpf_meas(lpf_a)
    );

    native2axis #(.DATA_WID(24), .FIFO_DEPTH(4), .CNT_WID(12)) dut_b (
        .clk(clk), .rst(rst), .natv_active(natv_active), .natv_data(natv_data),
        .natv_hsync(natv_hsync), .natv_vsync(natv_vsync), .natv_hblank(natv_hblank),
        .natv_vblank(natv_vblank), .m_axis_tdata(tdata_b), .m_axis_tkeep(tkeep_b),
        .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b), .m_axis_tuser(tuser_b),
        .m_axis_tlast(tlast_b), .ovf_clr(ovf_clr), .ovf_sticky(ovf_b),
        .ppl_meas(ppl_b), .lpf_meas(lpf_b)
    );

    // Beats are logged at the falling edge; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid_a && tready_a) q_a.push_back({tuser_a, tlast_a, tdata_a});
            if (tvalid_b && tready_b) q_b.push_back({tuser_b, tlast_b, tdata_b});
            if (stall_a && (!tvalid_a || ({tuser_a, tlast_a, tdata_a} !== held_a)))
                stall_err <= stall_err + 1;
            stall_a <= tvalid_a && !tready_a;
            held_a  <= {tuser_a, tlast_a, tdata_a};
        end else begin
            stall_a <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) tready_a = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        natv_active = 1'b0;
        natv_hblank = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vblank_pulse();
        natv_active = 1'b0;
        natv_vblank = 1'b1;
        natv_vsync  = 1'b1;
        tick();
        tick();
        natv_vblank = 1'b0;
        natv_vsync  = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int n, input logic [23:0] base);
        for (int p = 0; p < n; p++) begin
            natv_active = 1'b1;
            natv_hblank = 1'b0;
            natv_data   = base + 24'(p);
            tick();
        end
        idle(4);
    endtask

    task automatic do_reset();
        natv_active = 1'b0;
        natv_vblank = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (tvalid_a !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", tvalid_a); end
        n_vec++; if (tdata_a !== 24'h0) begin n_err++; $display("FAIL rst_tdata: got %h want 000000", tdata_a); end
        n_vec++; if ({tuser_a, tlast_a} !== 2'b00) begin n_err++; $display("FAIL rst_user_last: got %b want 00", {tuser_a, tlast_a}); end
        n_vec++; if (tkeep_a !== 3'b111) begin n_err++; $display("FAIL rst_tkeep: got %b want 111", tkeep_a); end
        n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf_a); end
        n_vec++; if (ppl_a !== 12'd0) begin n_err++; $display("FAIL rst_ppl: got %0d want 0", ppl_a); end
        n_vec++; if (lpf_a !== 12'd0) begin n_err++; $display("FAIL rst_lpf: got %0d want 0", lpf_a); end
    endtask

    task automatic test_frame_8x4();
        int          a0;
        logic [25:0] exp;
        do_reset();
        tready_a = 1'b1;
        a0 = q_a.size();
        vblank_pulse();
        for (int p = 0; p < 8; p++) begin
            natv_active = 1'b1;
            natv_hblank = 1'b0;
            natv_data   = 24'h010000 + 24'(p);
            tick();
            if (p == 1) begin
                n_vec++; if (tvalid_a !== 1'b0) begin n_err++; $display("FAIL lat_k1_tvalid: got %b want 0", tvalid_a); end
            end
            if (p == 2) begin
                n_vec++; if (tvalid_a !== 1'b1) begin n_err++; $display("FAIL lat_k2_tvalid: got %b want 1", tvalid_a); end
            end
        end
        idle(4);
        for (int l = 1; l < 4; l++) send_line(8, 24'h010000 + 24'(l * 8));
        vblank_pulse();
        idle(10);
        n_vec++; if (q_a.size() - a0 !== 32) begin n_err++; $display("FAIL f8x4_beats: got %0d want 32", q_a.size() - a0); end
        for (int i = 0; i < 32; i++) begin
            if (a0 + i < q_a.size()) begin
                exp = {(i == 0), ((i % 8) == 7), 24'h010000 + 24'(i)};
                n_vec++; if (q_a[a0 + i] !== exp) begin n_err++; $display("FAIL f8x4_beat%0d: got %h want %h", i, q_a[a0 + i], exp); end
            end
        end
        n_vec++; if (ppl_a !== 12'd8) begin n_err++; $display("FAIL f8x4_ppl: got %0d want 8", ppl_a); end
        n_vec++; if (lpf_a !== 12'd4) begin n_err++; $display("FAIL f8x4_lpf: got %0d want 4", lpf_a); end
    endtask

    task automatic test_pre_vblank();
        int          a0;
        logic [25:0] exp;
        do_reset();
        tready_a = 1'b1;
        a0 = q_a.size();
        send_line(8, 24'h0A0000);
        idle(6);
        n_vec++; if (q_a.size() - a0 !== 0) begin n_err++; $display("FAIL prevb_no_beats: got %0d want 0", q_a.size() - a0); end
        vblank_pulse();
        send_line(4, 24'h0B0000);
        idle(6);
        n_vec++; if (q_a.size() - a0 !== 4) begin n_err++; $display("FAIL prevb_beats: got %0d want 4", q_a.size() - a0); end
        for (int i = 0; i < 4; i++) begin
            if (a0 + i < q_a.size()) begin
                exp = {(i == 0), (i == 3), 24'h0B0000 + 24'(i)};
                n_vec++; if (q_a[a0 + i] !== exp) begin n_err++; $display("FAIL prevb_beat%0d: got %h want %h", i, q_a[a0 + i], exp); end
            end
        end
    endtask

    task automatic test_overflow();
        int          b0;
        int          b1;
        logic [25:0] exp;
        do_reset();
        tready_b = 1'b0;
        b0 = q_b.size();
        vblank_pulse();
        send_line(8, 24'h000100);
        idle(2);
        n_vec++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf_b); end
        n_vec++; if (tvalid_b !== 1'b1) begin n_err++; $display("FAIL ovf_tvalid_held: got %b want 1", tvalid_b); end
        tready_b = 1'b1;
        idle(8);
        n_vec++; if (q_b.size() - b0 !== 4) begin n_err++; $display("FAIL ovf_retained: got %0d want 4", q_b.size() - b0); end
        for (int i = 0; i < 4; i++) begin
            if (b0 + i < q_b.size()) begin
                exp = {(i == 0), 1'b0, 24'h000100 + 24'(i)};
                n_vec++; if (q_b[b0 + i] !== exp) begin n_err++; $display("FAIL ovf_beat%0d: got %h want %h", i, q_b[b0 + i], exp); end
            end
        end
        b1 = q_b.size();
        send_line(3, 24'h000180);
        vblank_pulse();
        send_line(3, 24'h000200);
        idle(8);
        n_vec++; if (q_b.size() - b1 !== 3) begin n_err++; $display("FAIL ovf_recover_beats: got %0d want 3", q_b.size() - b1); end
        for (int i = 0; i < 3; i++) begin
            if (b1 + i < q_b.size()) begin
                exp = {(i == 0), (i == 2), 24'h000200 + 24'(i)};
                n_vec++; if (q_b[b1 + i] !== exp) begin n_err++; $display("FAIL ovf_recover_beat%0d: got %h want %h", i, q_b[b1 + i], exp); end
            end
        end
        n_vec++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL ovf_still_set: got %b want 1", ovf_b); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_vec++; if (ovf_b !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", ovf_b); end
    endtask

    task automatic test_random_ready();
        int          a0;
        int          s0;
        logic [25:0] exp;
        do_reset();
        a0 = q_a.size();
        s0 = stall_err;
        rand_rdy = 1'b1;
        vblank_pulse();
        for (int l = 0; l < 3; l++) send_line(16, 24'h300000 + 24'(l * 16));
        vblank_pulse();
        rand_rdy = 1'b0;
        tready_a = 1'b1;
        idle(60);
        n_vec++; if (q_a.size() - a0 !== 48) begin n_err++; $display("FAIL rnd_beats: got %0d want 48", q_a.size() - a0); end
        for (int i = 0; i < 48; i++) begin
            if (a0 + i < q_a.size()) begin
                exp = {(i == 0), ((i % 16) == 15), 24'h300000 + 24'(i)};
                n_vec++; if (q_a[a0 + i] !== exp) begin n_err++; $display("FAIL rnd_beat%0d: got %h want %h", i, q_a[a0 + i], exp); end
            end
        end
        n_vec++; if (stall_err - s0 !== 0) begin n_err++; $display("FAIL rnd_stall_stable: got %0d unstable cycles want 0", stall_err - s0); end
        n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL rnd_ovf: got %b want 0", ovf_a); end
        n_vec++; if (ppl_a !== 12'd16) begin n_err++; $display("FAIL rnd_ppl: got %0d want 16", ppl_a); end
        n_vec++; if (lpf_a !== 12'd3) begin n_err++; $display("FAIL rnd_lpf: got %0d want 3", lpf_a); end
    endtask

    task automatic test_single_pixel_lines();
        int          a0;
        logic [25:0] exp;
        do_reset();
        tready_a = 1'b1;
        a0 = q_a.size();
        vblank_pulse();
        for (int l = 0; l < 3; l++) send_line(1, 24'h500000 + 24'(l));
        vblank_pulse();
        idle(6);
        n_vec++; if (q_a.size() - a0 !== 3) begin n_err++; $display("FAIL spl_beats: got %0d want 3", q_a.size() - a0); end
        for (int i = 0; i < 3; i++) begin
            if (a0 + i < q_a.size()) begin
                exp = {(i == 0), 1'b1, 24'h500000 + 24'(i)};
                n_vec++; if (q_a[a0 + i] !== exp) begin n_err++; $display("FAIL spl_beat%0d: got %h want %h", i, q_a[a0 + i], exp); end
            end
        end
        n_vec++; if (ppl_a !== 12'd1) begin n_err++; $display("FAIL spl_ppl: got %0d want 1", ppl_a); end
        n_vec++; if (lpf_a !== 12'd3) begin n_err++; $display("FAIL spl_lpf: got %0d want 3", lpf_a); end
    endtask

    task automatic test_reset_midline();
        int a1;
        do_reset();
        tready_a = 1'b1;
        tready_b = 1'b0;
        vblank_pulse();
        send_line(4, 24'h600000);
        vblank_pulse();
        send_line(4, 24'h600010);
        tready_a = 1'b0;
        for (int p = 0; p < 6; p++) begin
            natv_active = 1'b1;
            natv_hblank = 1'b0;
            natv_data   = 24'h600020 + 24'(p);
            tick();
        end
        n_vec++; if (tvalid_a !== 1'b1) begin n_err++; $display("FAIL rml_pre_tvalid: got %b want 1", tvalid_a); end
        n_vec++; if (ppl_a !== 12'd4) begin n_err++; $display("FAIL rml_pre_ppl: got %0d want 4", ppl_a); end
        n_vec++; if (lpf_a !== 12'd1) begin n_err++; $display("FAIL rml_pre_lpf: got %0d want 1", lpf_a); end
        n_vec++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL rml_pre_ovf: got %b want 1", ovf_b); end
        rst = 1'b1;
        tick();
        n_vec++; if (tvalid_a !== 1'b0) begin n_err++; $display("FAIL rml_tvalid: got %b want 0", tvalid_a); end
        n_vec++; if (ppl_a !== 12'd0) begin n_err++; $display("FAIL rml_ppl: got %0d want 0", ppl_a); end
        n_vec++; if (lpf_a !== 12'd0) begin n_err++; $display("FAIL rml_lpf: got %0d want 0", lpf_a); end
        n_vec++; if (ovf_b !== 1'b0) begin n_err++; $display("FAIL rml_ovf: got %b want 0", ovf_b); end
        rst = 1'b0;
        tready_a = 1'b1;
        tready_b = 1'b1;
        a1 = q_a.size();
        tick();
        tick();
        idle(4);
        send_line(4, 24'h600040);
        idle(6);
        n_vec++; if (q_a.size() - a1 !== 0) begin n_err++; $display("FAIL rml_wait_sof: got %0d beats want 0", q_a.size() - a1); end
    endtask

    initial begin
        test_reset();
        test_frame_8x4();
        test_pre_vblank();
        test_overflow();
        test_random_ready();
        test_single_pixel_lines();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/native2axis.md
Name: native2axis

Overview:
- Converts a free-running native video stream (active/hsync/vsync/hblank/vblank/data), as produced by the VTG/capture path, into AXI4-Stream video (tuser = SOF, tlast = EOL).
- Return-path counterpart of the AXIS-to-native converter. Feeds a VDMA S2MM port for frame capture into DDR.
- Single clock domain. Any CDC is handled upstream or downstream.
- Contains an elastic FIFO, because the native side cannot stall.

Parameters:
- DATA_WID, 24: pixel width; also the tdata width.
- FIFO_DEPTH, 2048: FIFO entries. Must be a power of 2 and ≥ 4.
- CNT_WID, 12: width of the measurement counters (ppl/lpf).

Ports:
- clk  in  1  pixel/stream clock.
- rst  in  1  synchronous, active-high reset.
- natv_active  in  1  active-video qualifier.
- natv_data  in  DATA_WID  pixel data; valid when natv_active=1.
- natv_hsync  in  1  horizontal sync; monitored only.
- natv_vsync  in  1  vertical sync; monitored only.
- natv_hblank  in  1  horizontal blank; unused, present for interface completeness.
- natv_vblank  in  1  vertical blank; its rising edge marks the frame boundary.
- m_axis_tdata  out  DATA_WID  pixel.
- m_axis_tkeep  out  DATA_WID/8  all ones, constant.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tuser  out  1  start of frame; set on the first pixel of a frame.
- m_axis_tlast  out  1  end of line; set on the last pixel of a line.
- ovf_clr  in  1  clears ovf_sticky.
- ovf_sticky  out  1  an overflow has occurred since the last clear.
- ppl_meas  out  CNT_WID  active pixels in the last completed line.
- lpf_meas  out  CNT_WID  active lines in the last completed frame.

Behaviour:
- Reset: all outputs 0 except m_axis_tkeep (all ones). FIFO empty. State = WAIT_SOF. Counters 0, sof_pending=0. Reset applied mid-frame discards FIFO contents immediately.
- vblank_rise: natv_vblank=1 while the registered previous value is 0.
- States:
  - WAIT_SOF: ignore active pixels. On vblank_rise go to RUN and set sof_pending=1.
  - RUN: capture pixels. On overflow go to DROP.
  - DROP: discard pixels until vblank_rise, then go to RUN with sof_pending=1.
- Every vblank_rise, in any state, sets sof_pending=1.
- Stage register: each active pixel accepted in RUN is held one cycle. Its tlast is resolved on the next cycle as tlast = ~natv_active. Its tuser = sof_pending at sample time. sof_pending clears once the pixel is staged.
- FIFO write: occurs the cycle after the sample. Write is allowed if the FIFO is not full, or if a read (tvalid&tready) happens in the same cycle.
- Latency: a pixel sampled at edge k is written at edge k+1. tvalid is visible after edge k+2 when the FIFO is empty and tready=1.
- Overflow: a staged pixel that cannot be written is dropped. Then set ovf_sticky=1 and enter DROP.
  - Entries already in the FIFO still drain. Downstream may see a truncated line without tlast; the VDMA is expected to flag this.
  - If ovf_clr and a new overflow occur in the same cycle, set wins.
- AXIS rules:
  - tvalid is held high until the handshake completes.
  - tdata/tuser/tlast are stable while tvalid&~tready.
  - No bubbles are inserted while the FIFO is non-empty.
- Single-pixel line (active high for 1 cycle): that pixel has tlast=1, and also tuser=1 if it is the first pixel of the frame.
- Back-to-back lines with zero blanking are not supported. At least 1 inactive cycle is required between lines.
- Measurement:
  - pix_cnt increments per accepted active pixel and saturates at 2^CNT_WID-1.
  - On line end, latch pix_cnt into ppl_meas, clear pix_cnt, and increment line_cnt (also saturating).
  - On vblank_rise, latch line_cnt into lpf_meas and clear line_cnt.
  - Counting runs in RUN and DROP; it is suspended in WAIT_SOF.
- Frame with 0 active lines: lpf_meas=0 and no tuser is emitted. sof_pending stays set for the next frame.

Decomposition:
- Package native2axis_pkg holds:
  - the state enum (WAIT_SOF, RUN, DROP);
  - the packed struct fifo_word_t {tuser, tlast, data[DATA_WID]};
  - the FIFO width function.
- Sub-module qwi_sync_fifo: single-clock, first-word-fall-through FIFO.
  - Ports: clk, rst, wr_en, wr_data, full, rd_en, rd_data, empty.
  - Registered output; count width log2(DEPTH)+1.
  - Reusable elsewhere in the codebase.

Test Plan:
- 8x4 frame, tready=1: after the first vblank_rise, expect 32 beats. Beat 0 has tuser=1; beats 7, 15, 23, 31 have tlast=1. Expect ppl_meas=8 and lpf_meas=4 after the next vblank. First tvalid appears 2 cycles after the first active sample.
- Active pixels present before any vblank after reset: no beats output until vblank_rise; the first emitted beat carries tuser.
- FIFO_DEPTH=4, tready=0, 8-pixel line: 4 entries retained and ovf_sticky=1. Remaining pixels are dropped until the next vblank, then the next frame starts cleanly with tuser=1. ovf_clr then returns ovf_sticky to 0.
- Random tready (50%) on a 16x3 frame: data order is preserved and outputs are stable while stalled. 48 beats total, with 3 tlast and 1 tuser.
- 1-pixel lines x3: each beat has tlast=1, the first beat also has tuser=1; ppl_meas=1, lpf_meas=3.
- rst asserted mid-line with the FIFO holding 5 entries: tvalid=0 on the next cycle, state returns to WAIT_SOF, and ovf_sticky/ppl_meas/lpf_meas read 0.
